immediate_encoder: RTL and testbench

IMMEDIATE_ENCODER -- requirements
Module: immediate_encoder

---
 rtl/cpu_shift_pkg.sv | 35 +++
 rtl/imm8_fit_check.sv | 21 ++
 rtl/immediate_encoder.sv | 124 ++++++++++++
 tb/tb_immediate_encoder.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_shift_pkg.sv
// Shared definitions for the ARM data-processing immediate encoder:
// FSM state encoding, immediate field widths and the rotate helper.
package cpu_shift_pkg;

  // Rotate field and 8-bit payload of a 12-bit ARM immediate.
  localparam int ROT_W   = 4;
  localparam int IMM8_W  = 8;
  localparam int IMM12_W = ROT_W + IMM8_W;

  // All sixteen even rotate amounts are searched by default.
  localparam int ROT_STEPS_DEFAULT = 16;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    DONE
  } enc_state_e;

  // Registered result presented on the out_* ports while in DONE.
  typedef struct packed {
    logic               ok;
    logic [IMM12_W-1:0] imm12;
    logic               inv;
    logic               carry;
    logic               c_upd;
  } enc_result_t;

  // Rotate left by 2*rot. A shift by 32 yields zero, so rot = 0 is the identity.
  function automatic logic [31:0] rol32(input logic [31:0] x, input logic [ROT_W-1:0] rot);
    logic [5:0] sh;
    sh = {1'b0, rot, 1'b0};
    return (x << sh) | (x >> (6'd32 - sh));
  endfunction

endpackage

// File: rtl/imm8_fit_check.sv
// Combinational test of whether a 32-bit value is representable as an
// 8-bit payload rotated right by 2*rot; also returns that payload.
module imm8_fit_check
  import cpu_shift_pkg::*;
(
  input  logic [31:0]       value,
  input  logic [ROT_W-1:0]  rot,
  output logic              fit,
  output logic [IMM8_W-1:0] imm8
);

  logic [31:0] rotated;

  // Undo the decoder's rotate-right; a fit leaves nothing above the low byte.
  always_comb begin
    rotated = rol32(value, rot);
    fit     = (rotated[31:IMM8_W] == '0);
    imm8    = rotated[IMM8_W-1:0];
  end

endmodule

// File: rtl/immediate_encoder.sv
// Sequential ARM immediate encoder: accepts a 32-bit constant, walks the
// rotate amounts one per clock testing both the value and its complement,
// and reports the first (lowest-rotate, plain-preferred) encoding found.
module immediate_encoder
  import cpu_shift_pkg::*;
#(
  parameter int ROT_STEPS = ROT_STEPS_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        in_value,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_ok,
  output logic [IMM12_W-1:0] out_imm12,
  output logic               out_inv,
  output logic               out_carry,
  output logic               out_c_upd
);

  localparam logic [ROT_W-1:0] ROT_LAST = ROT_W'(ROT_STEPS - 1);

  enc_state_e        state, state_nxt;
  logic [ROT_W-1:0]  rot_cnt, rot_cnt_nxt;
  enc_result_t       res, res_nxt;
  logic              load;

  logic [31:0]       val_plain, val_inv;
  logic              fit_plain, fit_inv;
  logic [IMM8_W-1:0] imm8_plain, imm8_inv;

  imm8_fit_check u_fit_plain (
    .value (val_plain),
    .rot   (rot_cnt),
    .fit   (fit_plain),
    .imm8  (imm8_plain)
  );

  imm8_fit_check u_fit_inv (
    .value (val_inv),
    .rot   (rot_cnt),
    .fit   (fit_inv),
    .imm8  (imm8_inv)
  );

  // Next-state, search step and result selection.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path infers a latch.
    state_nxt   = state;
    rot_cnt_nxt = rot_cnt;
    res_nxt     = res;
    load        = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          load        = 1'b1;
          rot_cnt_nxt = '0;
          state_nxt   = SEARCH;
        end
      end
      SEARCH: begin
        if (fit_plain) begin
          // Decoded value equals the tested value, so its MSB is the shifter carry.
          res_nxt.ok    = 1'b1;
          res_nxt.imm12 = {rot_cnt, imm8_plain};
          res_nxt.inv   = 1'b0;
          res_nxt.carry = (rot_cnt != '0) && val_plain[31];
          res_nxt.c_upd = (rot_cnt != '0);
          state_nxt     = DONE;
        end else if (fit_inv) begin
          res_nxt.ok    = 1'b1;
          res_nxt.imm12 = {rot_cnt, imm8_inv};
          res_nxt.inv   = 1'b1;
          res_nxt.carry = (rot_cnt != '0) && val_inv[31];
          res_nxt.c_upd = (rot_cnt != '0);
          state_nxt     = DONE;
        end else if (rot_cnt == ROT_LAST) begin
          res_nxt   = '0;
          state_nxt = DONE;
        end else begin
          rot_cnt_nxt = rot_cnt + ROT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, rotate counter and result registers.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!reset_n) begin
      state   <= IDLE;
      rot_cnt <= '0;
      res     <= '0;
    end else begin
      state   <= state_nxt;
      rot_cnt <= rot_cnt_nxt;
      res     <= res_nxt;
    end
  end

  // Operand capture on acceptance; held unchanged for the whole search.
  always_ff @(posedge clk) begin
    // NOTE: pure datapath, only read in SEARCH after a load, so it needs no reset.
    if (load) begin
      val_plain <= in_value;
      val_inv   <= ~in_value;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign out_ok    = res.ok;
  assign out_imm12 = res.imm12;
  assign out_inv   = res.inv;
  assign out_carry = res.carry;
  assign out_c_upd = res.c_upd;

endmodule

// File: tb/tb_immediate_encoder.sv
// Directed self-checking bench for immediate_encoder.
module tb_immediate_encoder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_value;
  logic        out_valid;
  logic        out_ready;
  logic        out_ok;
  logic [11:0] out_imm12;
  logic        out_inv;
  logic        out_carry;
  logic        out_c_upd;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  immediate_encoder dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ok    (out_ok),
    .out_imm12 (out_imm12),
    .out_inv   (out_inv),
    .out_carry (out_carry),
    .out_c_upd (out_c_upd)
  );

  typedef struct {
    logic [31:0] value;
    logic        ok;
    logic [11:0] imm12;
    logic        inv;
    logic        carry;
    logic        c_upd;
    int          lat;
  } vec_t;

  // Called #1 after an edge with the block idle; the next edge is the accept edge.
  // After acceptance the input is scrambled to show it is not re-sampled.
  task automatic accept(input logic [31:0] v);
    in_value = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_value = ~v;
  endtask

  // Edges after the accept edge until out_valid is seen; -1 on timeout.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_value  = '0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_ok !== 1'b0 || out_imm12 !== 12'h000 ||
        out_inv !== 1'b0 || out_carry !== 1'b0 || out_c_upd !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b ok=%b imm=%h inv=%b c=%b cu=%b required all 0",
               out_valid, out_ok, out_imm12, out_inv, out_carry, out_c_upd);
    end
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_encode;
    vec_t vecs[$];
    int   lat;
    vecs.push_back('{32'h000000FF, 1'b1, 12'h0FF, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{32'hFF000000, 1'b1, 12'h4FF, 1'b0, 1'b1, 1'b1, 5});
    vecs.push_back('{32'h00000104, 1'b1, 12'hF41, 1'b0, 1'b0, 1'b1, 16});
    vecs.push_back('{32'hFFFFFF00, 1'b1, 12'h0FF, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{32'h00000101, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 16});
    vecs.push_back('{32'h00000000, 1'b1, 12'h000, 1'b0, 1'b0, 1'b0, 1});
    vecs.push_back('{32'hC000003F, 1'b1, 12'h1FF, 1'b0, 1'b1, 1'b1, 2});
    vecs.push_back('{32'h00FFFFFF, 1'b1, 12'h4FF, 1'b1, 1'b1, 1'b1, 5});
    vecs.push_back('{32'h000000F0, 1'b1, 12'h0F0, 1'b0, 1'b0, 1'b0, 1});
    foreach (vecs[i]) begin
      accept(vecs[i].value);
      wait_valid(lat);
      checks++;
      if (lat !== vecs[i].lat) begin
        errors++;
        $display("FAIL latency[%h]: got %0d required %0d", vecs[i].value, lat, vecs[i].lat);
      end
      checks++;
      if (out_ok !== vecs[i].ok) begin
        errors++;
        $display("FAIL ok[%h]: got %b required %b", vecs[i].value, out_ok, vecs[i].ok);
      end
      checks++;
      if (out_imm12 !== vecs[i].imm12) begin
        errors++;
        $display("FAIL imm12[%h]: got %h required %h", vecs[i].value, out_imm12, vecs[i].imm12);
      end
      checks++;
      if (out_inv !== vecs[i].inv) begin
        errors++;
        $display("FAIL inv[%h]: got %b required %b", vecs[i].value, out_inv, vecs[i].inv);
      end
      checks++;
      if (out_carry !== vecs[i].carry || out_c_upd !== vecs[i].c_upd) begin
        errors++;
        $display("FAIL carry[%h]: got c=%b cu=%b required c=%b cu=%b", vecs[i].value,
                 out_carry, out_c_upd, vecs[i].carry, vecs[i].c_upd);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      checks++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL handshake[%h]: got in_ready=%b out_valid=%b required 1/0",
                 vecs[i].value, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_back_to_back;
    int   lat;
    logic held_ok;
    accept(32'h000000FF);
    wait_valid(lat);
    checks++;
    if (lat !== 1 || out_imm12 !== 12'h0FF) begin
      errors++;
      $display("FAIL bp_first: got lat=%0d imm=%h required 1/0ff", lat, out_imm12);
    end
    // Hold the result while a new request waits on the input.
    in_valid = 1'b1;
    in_value = 32'hFF000000;
    held_ok  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_ok !== 1'b1 ||
          out_imm12 !== 12'h0FF || out_inv !== 1'b0 || out_c_upd !== 1'b0)
        held_ok = 1'b0;
    end
    checks++;
    if (held_ok !== 1'b1) begin
      errors++;
      $display("FAIL bp_hold: got v=%b rdy=%b imm=%h required 1/0/0ff stable",
               out_valid, in_ready, out_imm12);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release: got in_ready=%b out_valid=%b required 1/0", in_ready, out_valid);
    end
    // in_valid still high: this edge is the accept edge.
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_value = 32'h0;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_accept: got in_ready=%b required 0", in_ready);
    end
    wait_valid(lat);
    checks++;
    if (lat !== 5 || out_ok !== 1'b1 || out_imm12 !== 12'h4FF || out_carry !== 1'b1) begin
      errors++;
      $display("FAIL bp_second: got lat=%0d ok=%b imm=%h c=%b required 5/1/4ff/1",
               lat, out_ok, out_imm12, out_carry);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset_midsearch;
    logic quiet;
    accept(32'h00000104);
    // Edges t+1..t+3 test rot 0..2; the counter now holds 3.
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_ok !== 1'b0 || out_imm12 !== 12'h000 ||
        out_inv !== 1'b0 || out_carry !== 1'b0 || out_c_upd !== 1'b0) begin
      errors++;
      $display("FAIL midreset_outputs: got rdy=%b v=%b ok=%b imm=%h inv=%b c=%b cu=%b required 1 then all 0",
               in_ready, out_valid, out_ok, out_imm12, out_inv, out_carry, out_c_upd);
    end
    reset_n = 1'b1;
    quiet   = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++;
      $display("FAIL midreset_stale: got out_valid=%b in_ready=%b required 0/1 throughout",
               out_valid, in_ready);
    end
  endtask

  initial begin
    test_reset();
    test_encode();
    test_back_to_back();
    test_reset_midsearch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

endmodule
